// File: rtl/pic24_bus_pkg.sv
// ---------------------------------------------------------------------------
// pic24_bus_pkg
// Shared types and default constants for the 24-bit tri-state data bus
// arbitration logic.
//   arb_state_t      : arbiter sequencer states (IDLE, GRANT, TURN)
//   BUS_WIDTH        : width of the shared data bus driven through the latches
//   DEF_N_REQ        : default number of requesters / bus latches
//   DEF_TURN_CYCLES  : default all-enables-off cycles between owners
//   DEF_MAX_HOLD     : default ownership limit when hold limiting is built in
// ---------------------------------------------------------------------------
package pic24_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int BUS_WIDTH       = 24;
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TURN_CYCLES = 1;
  localparam int DEF_MAX_HOLD    = 16;

endpackage : pic24_bus_pkg

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin winner selection. The search starts at the
// requester just after last_i and wraps, so last_i itself is checked last
// (lowest priority). Generic enough for any shared-resource arbiter.
//
// Ports:
//   req_i    [N_REQ-1:0]  request vector
//   last_i   [ID_W-1:0]   index of the previous owner
//   grant_o  [N_REQ-1:0]  one-hot winner (all zero when no request)
//   idx_o    [ID_W-1:0]   index of the winner (0 when no request)
//   any_o                 at least one request is present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    logic [ID_W-1:0] w_k;
    // NOTE: every output gets a default before the search loop; a path that
    // leaves one unassigned would infer a latch.
    w_k     = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Offsets 1..N_REQ from the last owner; offset N_REQ lands back on the
    // last owner, so it only wins when nobody else is asking.
    for (int i = 1; i <= N_REQ; i++) begin
      w_k = ID_W'((int'(last_i) + i) % N_REQ);
      if (!any_o && req_i[w_k]) begin
        any_o        = 1'b1;
        grant_o[w_k] = 1'b1;
        idx_o        = w_k;
      end
    end
  end

endmodule : rr_priority_picker

// File: rtl/bus_arbiter_24bit.sv
// ---------------------------------------------------------------------------
// bus_arbiter_24bit
// Round-robin arbiter and sequencer for the shared 24-bit tri-state data bus.
// Each requester owns one 24-bit bus latch; this block produces the latch
// enables. At most one enable is ever high, and between two owners all
// enables stay low for exactly TURN_CYCLES cycles so drivers never overlap.
//
// Build option:
//   BUS_ARB_MAXHOLD_EN  when defined, an owner is forced off the bus after
//                       MAX_HOLD consecutive granted cycles; when undefined,
//                       ownership lasts as long as the request is held.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   req_i     [N_REQ-1:0] level-held bus requests
//   en_o      [N_REQ-1:0] registered one-hot-or-zero latch enables
//   gnt_id_o  [ID_W-1:0]  current owner index, meaningful while en_o != 0
//   busy_o    high while in GRANT or TURN
// ---------------------------------------------------------------------------
module bus_arbiter_24bit
  import pic24_bus_pkg::*;
#(
  parameter  int N_REQ       = DEF_N_REQ,
  parameter  int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter  int MAX_HOLD    = DEF_MAX_HOLD,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] en_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             busy_o
);

  // Sized to hold TURN_CYCLES-1, never narrower than one bit.
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TURN_CYCLES < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter_24bit: parameter out of legal range");
  end

  arb_state_t        r_state,    w_state_nxt;
  logic [N_REQ-1:0]  r_en,       w_en_nxt;
  logic [ID_W-1:0]   r_gnt_id,   w_gnt_nxt;
  logic [ID_W-1:0]   r_last,     w_last_nxt;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              w_release;
  logic              w_take;

`ifdef BUS_ARB_MAXHOLD_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
`endif

  logic [N_REQ-1:0] w_pick_onehot;
  logic [ID_W-1:0]  w_pick_idx;
  logic             w_pick_any;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i   (req_i),
    .last_i  (r_last),
    .grant_o (w_pick_onehot),
    .idx_o   (w_pick_idx),
    .any_o   (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_gnt_nxt   = r_gnt_id;
    w_last_nxt  = r_last;
    w_turn_nxt  = r_turn_cnt;
    w_release   = 1'b0;
    w_take      = 1'b0;
`ifdef BUS_ARB_MAXHOLD_EN
    w_hold_nxt  = r_hold_cnt;
`endif

    case (r_state)
      IDLE: begin
        w_en_nxt = '0;
        w_take   = w_pick_any;
      end

      GRANT: begin
        w_release = !req_i[r_gnt_id];
`ifdef BUS_ARB_MAXHOLD_EN
        // r_hold_cnt equals the number of cycles en_o has already been high.
        if (r_hold_cnt == HOLD_W'(MAX_HOLD)) begin
          w_release = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
`endif
        if (w_release) begin
          w_en_nxt    = '0;
          w_last_nxt  = r_gnt_id;
          w_turn_nxt  = TURN_W'(TURN_CYCLES - 1);
          w_state_nxt = TURN;
        end
      end

      TURN: begin
        w_en_nxt = '0;
        if (r_turn_cnt != '0) begin
          w_turn_nxt = r_turn_cnt - 1'b1;
        end else if (w_pick_any) begin
          w_take = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_en_nxt    = '0;
        w_state_nxt = IDLE;
      end
    endcase

    // Arbitration outcome shared by IDLE and the last TURN cycle.
    if (w_take) begin
      w_state_nxt = GRANT;
      w_en_nxt    = w_pick_onehot;
      w_gnt_nxt   = w_pick_idx;
`ifdef BUS_ARB_MAXHOLD_EN
      w_hold_nxt  = HOLD_W'(1);
`endif
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // The asynchronous reset drops every enable immediately, so the bus floats
  // even if reset arrives mid-grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_en       <= '0;
      r_gnt_id   <= '0;
      r_last     <= ID_W'(N_REQ - 1);
      r_turn_cnt <= '0;
      r_busy     <= 1'b0;
`ifdef BUS_ARB_MAXHOLD_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_state    <= w_state_nxt;
      r_en       <= w_en_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_last     <= w_last_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_busy     <= w_busy_nxt;
`ifdef BUS_ARB_MAXHOLD_EN
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end

  assign en_o     = r_en;
  assign gnt_id_o = r_gnt_id;
  assign busy_o   = r_busy;

endmodule : bus_arbiter_24bit

// File: doc/bus_arbiter_24bit.md
Name: bus_arbiter_24bit

Overview:
- Round-robin arbiter and sequencer for the shared 24-bit tri-state data bus.
- Each requester drives the bus through its own 24-bit tri-state latch; this block produces one latch enable per requester.
- Guarantees at most one enable is active at a time, with enforced all-off turnaround cycles between owners so drivers never contend.
- Sits between the bus masters (fetch, data RAM, peripherals) and their bus latches.

Parameters:
- N_REQ, 4, number of requesters/latches; legal range 2..8.
- TURN_CYCLES, 1, all-enables-off cycles between consecutive owners; legal range >=1.
- MAX_HOLD, 16, maximum consecutive granted cycles per ownership (used only with the optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  N_REQ  per-requester bus request, level-held.
- en_o  output  N_REQ  registered one-hot or zero latch enables; bit n drives latch n en_i.
- gnt_id_o  output  $clog2(N_REQ)  index of the current owner; valid only while en_o != 0.
- busy_o  output  1  high in GRANT or TURN.

Behaviour:
- Reset values, applied immediately on rst_i high:
  - state = IDLE; en_o = 0; gnt_id_o = 0; busy_o = 0.
  - last-owner pointer = N_REQ-1, so requester 0 has top priority first.
  - turnaround and hold counters = 0.
- All outputs are registered. Nothing is combinational from req_i.
- States:
  - IDLE: en_o = 0. If any req_i bit is high at a clock edge, pick the winner round-robin: the first requester after the last owner, wrapping. Register en_o[w] = 1 and gnt_id_o = w, go to GRANT. Latency: req_i high before edge k gives en_o high after edge k.
  - GRANT: en_o holds the owner while req_i[owner] stays high. When req_i[owner] is sampled low, clear en_o at that edge, update last-owner pointer, load the turn counter with TURN_CYCLES-1, go to TURN.
  - TURN: en_o = 0 and busy_o = 1.
    - While the counter is > 0, decrement it.
    - When the counter is 0, arbitrate exactly as in IDLE at that edge: a winner goes to GRANT, no request goes to IDLE.
    - Net effect: en_o is all-zero for exactly TURN_CYCLES cycles between owners.
- Round-robin:
  - The previous owner has the lowest priority at the next arbitration.
  - If the previous owner is the only requester, it wins again, still after the turnaround.
- Simultaneous events:
  - Requests arriving during GRANT or TURN wait; they are never preempted or dropped while held.
  - A request that drops before it is granted is forgotten (level-sensitive).
  - Owner dropping req in the same cycle others assert: normal TURN, then round-robin.
- Invariant: $countones(en_o) <= 1 in every cycle, including cycles during reset assertion.
- Reset mid-GRANT: en_o clears asynchronously in the same cycle; the bus floats; the pointer restarts.

Optional Feature:
- Macro: BUS_ARB_MAXHOLD_EN.
- Defined:
  - A hold counter counts en_o-active cycles.
  - When the owner has held for MAX_HOLD cycles, en_o clears at the next edge even if req_i[owner] is still high. Enter TURN with the owner at lowest priority.
  - A still-requesting owner is re-granted only by round-robin.
- Undefined:
  - No hold counter; ownership is unbounded while req is held; the MAX_HOLD parameter is ignored.

Decomposition:
- Package pic24_bus_pkg:
  - arb_state_t enum {IDLE, GRANT, TURN}.
  - BUS_WIDTH = 24.
  - Default N_REQ / TURN_CYCLES / MAX_HOLD constants.
- Sub-module rr_priority_picker: combinational.
  - Inputs: req vector and last-owner index.
  - Outputs: one-hot winner, winner index, any-valid.
  - Reused by other shared-resource arbiters.

Test Plan:
- Reset then req_i = 4'b0001 -> en_o = 0001 one cycle after the request edge, gnt_id_o = 0, busy_o = 1; drop req -> en_o = 0 for 1 cycle, then IDLE with busy_o = 0.
- req_i = 4'b1111 held, each owner releases after 3 granted cycles -> grant order 0,1,2,3,0; exactly TURN_CYCLES = 1 zero-enable cycle between owners; en_o never multi-hot.
- Owner 2 drops req in the same cycle req 1 and req 3 rise -> next grant to 3 (after 2), then 1.
- TURN_CYCLES = 3, owner 0 releases while req 1 pending -> en_o = 0 for exactly 3 cycles, then en_o = 0010.
- rst_i pulsed mid-GRANT with en_o = 0100 -> en_o = 0 in the same cycle before the next clock edge; after release, req 1 and req 3 both high -> grant to 1 (pointer reset).
- BUS_ARB_MAXHOLD_EN, MAX_HOLD = 16, req 0 and req 1 held -> owner 0 gets exactly 16 cycles, 1-cycle turn, then owner 1 gets 16 cycles; without the macro, owner 0 holds indefinitely.
